// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word and byte-mask types
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fair two-port arbiter (A instr read, B data read/write) onto one pmem port
module mem_arbiter
  import lc3b_types::*;
#(
  parameter bit B_PRIORITY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read_a,
  input  lc3b_word      address_a,
  output logic          resp_a,
  output lc3b_word      rdata_a,
  input  logic          read_b,
  input  logic          write_b,
  input  lc3b_mem_wmask wmask_b,
  input  lc3b_word      address_b,
  input  lc3b_word      wdata_b,
  output logic          resp_b,
  output lc3b_word      rdata_b,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);
  typedef enum logic [2:0] {IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B} state_t;
  state_t state_q, state_d;
  logic fair_a_q, fair_a_d, fair_b_q, fair_b_d, write_q, write_d;
  logic req_a, req_b, grant_b, serve;
  lc3b_word addr_q, addr_d, wdata_q, wdata_d, rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  lc3b_mem_wmask wmask_q, wmask_d;
  always_comb begin
    req_a = read_a;
    req_b = read_b | write_b;
    // a pending flag on A overrides both B's flag and the static priority
    grant_b = req_b & (~req_a | (~fair_a_q & (fair_b_q | B_PRIORITY)));
    serve = (state_q == SERVE_A) || (state_q == SERVE_B);
    state_d = state_q;
    fair_a_d = fair_a_q;
    fair_b_d = fair_b_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    write_d = write_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (state_q == IDLE && (req_a || req_b)) begin
      state_d = grant_b ? SERVE_B : SERVE_A;
      fair_a_d = grant_b ? (fair_a_q | req_a) : 1'b0;
      fair_b_d = grant_b ? 1'b0 : (fair_b_q | req_b);
      addr_d = grant_b ? address_b : address_a;
      wdata_d = grant_b ? wdata_b : '0;
      wmask_d = grant_b ? wmask_b : '0;
      write_d = grant_b & write_b;
    end else if (serve && pmem_resp) begin
      state_d = (state_q == SERVE_A) ? DONE_A : DONE_B;
      rdata_a_d = (state_q == SERVE_A && !write_q) ? pmem_rdata : rdata_a_q;
      rdata_b_d = (state_q == SERVE_B && !write_q) ? pmem_rdata : rdata_b_q;
    end else if (state_q == DONE_A || state_q == DONE_B) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fair_a_q <= 1'b0;
      fair_b_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      write_q <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q <= state_d;
      fair_a_q <= fair_a_d;
      fair_b_q <= fair_b_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      write_q <= write_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end
  assign resp_a = state_q == DONE_A;
  assign resp_b = state_q == DONE_B;
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign pmem_read = serve & ~write_q;
  assign pmem_write = serve & write_q;
  assign pmem_wmask = serve ? wmask_q : '0;
  assign pmem_address = serve ? addr_q : '0;
  assign pmem_wdata = serve ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner sequences with a response scoreboard
module tb_mem_arbiter;
  import lc3b_types::*;
  logic clk = 1'b0;
  logic rst, read_a, read_b, write_b, pmem_resp;
  lc3b_word address_a, address_b, wdata_b, pmem_rdata;
  lc3b_mem_wmask wmask_b;
  logic resp_a, resp_b, pmem_read, pmem_write;
  lc3b_word rdata_a, rdata_b, pmem_address, pmem_wdata;
  lc3b_mem_wmask pmem_wmask;
  mem_arbiter #(.B_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst), .read_a(read_a), .address_a(address_a), .resp_a(resp_a),
    .rdata_a(rdata_a), .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b),
    .address_b(address_b), .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit pb;
    bit rd_b;
    bit wr_b;
    lc3b_word addr;
    lc3b_word wdata;
    lc3b_mem_wmask wmask;
    int dly;
    lc3b_word prd;
    logic [35:0] exp_pm;
    lc3b_word exp_rd;
  } vec_t;
  typedef struct packed {
    logic pb;
    lc3b_word rd;
  } sb_t;
  vec_t vecs[7];
  sb_t sb[$];
  int checks = 0;
  int errors = 0;
  lc3b_word ma, mb;
  int n;
  function automatic logic [35:0] pm_vec();
    return {pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata};
  endfunction
  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs();
    read_a = 0; read_b = 0; write_b = 0;
    address_a = '0; address_b = '0; wdata_b = '0; wmask_b = '0;
  endtask
  task automatic wait_pmem(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(pmem_read || pmem_write) && cnt < 20);
    if (!(pmem_read || pmem_write)) check("pmem_timeout", 0, 1);
  endtask
  task automatic complete(input bit pb, input int dly, input lc3b_word rd, input logic [35:0] exp_pm);
    for (int i = 0; i < dly; i++) begin
      check("pmem_hold", pm_vec(), exp_pm);
      @(negedge clk);
    end
    pmem_resp = 1; pmem_rdata = rd;
    @(posedge clk);
    #1 pmem_resp = 0; pmem_rdata = '0;
    @(negedge clk);
    check("resp_pulse", {resp_a, resp_b}, pb ? 2'b01 : 2'b10);
  endtask
  initial begin
    rst = 1; pmem_resp = 0; pmem_rdata = '0; ma = '0; mb = '0;
    idle_inputs();
    vecs[0] = '{0, 0, 0, 16'h0040, 16'h0000, 2'b00, 3, 16'h1234, {1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000}, 16'h1234};
    vecs[1] = '{1, 0, 1, 16'h8000, 16'hBEEF, 2'b01, 0, 16'hDEAD, {1'b0, 1'b1, 2'b01, 16'h8000, 16'hBEEF}, 16'h0000};
    vecs[2] = '{1, 1, 0, 16'h0100, 16'h0000, 2'b11, 1, 16'h5A5A, {1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000}, 16'h5A5A};
    vecs[3] = '{1, 1, 1, 16'h0200, 16'h1111, 2'b10, 2, 16'h9999, {1'b0, 1'b1, 2'b10, 16'h0200, 16'h1111}, 16'h5A5A};
    vecs[4] = '{0, 0, 0, 16'hFFFE, 16'h0000, 2'b00, 0, 16'hFFFF, {1'b1, 1'b0, 2'b00, 16'hFFFE, 16'h0000}, 16'hFFFF};
    vecs[5] = '{1, 0, 1, 16'h0002, 16'h0F0F, 2'b11, 1, 16'h7777, {1'b0, 1'b1, 2'b11, 16'h0002, 16'h0F0F}, 16'h5A5A};
    vecs[6] = '{0, 0, 0, 16'h0000, 16'h0000, 2'b00, 5, 16'h0000, {1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000}, 16'h0000};
    #1 check("reset_outputs", {resp_a, resp_b, rdata_a, rdata_b, pm_vec()}, '0);
    repeat (2) @(negedge clk);
    rst = 0;
    fork
      forever begin
        @(negedge clk);
        if (!rst && (resp_a || resp_b)) begin
          check("resp_exclusive", {1'b0, resp_a & resp_b}, 0);
          if (sb.size() == 0) check("unexpected_resp", {resp_a, resp_b}, 0);
          else begin
            sb_t e;
            e = sb.pop_front();
            check("sb_resp", {resp_b, resp_b ? rdata_b : rdata_a}, e);
          end
        end
      end
    join_none
    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].pb) begin
        read_b = vecs[k].rd_b; write_b = vecs[k].wr_b; address_b = vecs[k].addr;
        wdata_b = vecs[k].wdata; wmask_b = vecs[k].wmask;
      end else begin
        read_a = 1; address_a = vecs[k].addr;
      end
      wait_pmem(n);
      check("grant_latency", n, 1);
      check("pmem_drive", pm_vec(), vecs[k].exp_pm);
      sb.push_back('{vecs[k].pb, vecs[k].exp_rd});
      complete(vecs[k].pb, vecs[k].dly, vecs[k].prd, vecs[k].exp_pm);
      idle_inputs();
      if (vecs[k].pb) mb = vecs[k].exp_rd;
      else ma = vecs[k].exp_rd;
      check("rdata_regs", {rdata_a, rdata_b}, {ma, mb});
    end
    @(negedge clk);
    read_b = 1; address_b = 16'h0010;
    wait_pmem(n);
    address_b = 16'h0020;
    sb.push_back('{1'b1, 16'h4242});
    complete(1'b1, 3, 16'h4242, {1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000});
    idle_inputs();
    mb = 16'h4242;
    @(negedge clk);
    read_a = 1; address_a = 16'h0A0A; read_b = 1; address_b = 16'h0B0B;
    wait_pmem(n);
    check("contest_b_first", pm_vec(), {1'b1, 1'b0, 2'b00, 16'h0B0B, 16'h0000});
    sb.push_back('{1'b1, 16'h2222});
    complete(1'b1, 1, 16'h2222, {1'b1, 1'b0, 2'b00, 16'h0B0B, 16'h0000});
    address_b = 16'h0C0C;
    wait_pmem(n);
    check("fair_latency", n, 2);
    check("fair_a_next", pm_vec(), {1'b1, 1'b0, 2'b00, 16'h0A0A, 16'h0000});
    sb.push_back('{1'b0, 16'h3333});
    complete(1'b0, 0, 16'h3333, {1'b1, 1'b0, 2'b00, 16'h0A0A, 16'h0000});
    read_a = 0;
    wait_pmem(n);
    check("b_after_a", pm_vec(), {1'b1, 1'b0, 2'b00, 16'h0C0C, 16'h0000});
    sb.push_back('{1'b1, 16'h4444});
    complete(1'b1, 0, 16'h4444, {1'b1, 1'b0, 2'b00, 16'h0C0C, 16'h0000});
    idle_inputs();
    ma = 16'h3333; mb = 16'h4444;
    check("rdata_after_fair", {rdata_a, rdata_b}, {ma, mb});
    @(negedge clk);
    read_a = 1; address_a = 16'h0300;
    wait_pmem(n);
    read_a = 0;
    rst = 1;
    #1 check("async_reset", {resp_a, resp_b, rdata_a, rdata_b, pm_vec()}, '0);
    @(negedge clk);
    rst = 0; pmem_resp = 1; pmem_rdata = 16'hABCD;
    repeat (2) begin
      @(negedge clk);
      check("late_resp_ignored", {resp_a, resp_b, rdata_a, pm_vec()}, '0);
    end
    pmem_resp = 0; pmem_rdata = '0;
    read_a = 1; address_a = 16'h0400;
    wait_pmem(n);
    check("idle_after_reset", n, 1);
    sb.push_back('{1'b0, 16'h5555});
    complete(1'b0, 1, 16'h5555, {1'b1, 1'b0, 2'b00, 16'h0400, 16'h0000});
    idle_inputs();
    check("rdata_after_reset", {rdata_a, rdata_b}, {16'h5555, 16'h0000});
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: B_PRIORITY, 1, when both ports request in IDLE with no pending-fairness flag, 1 grants port B and 0 grants port A.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: read_a  in  1  instruction-port read request, level, held until resp_a.
REQ-005 SHALL have ports: address_a  in  16  instruction byte address.
REQ-006 SHALL have ports: resp_a  out  1  one-cycle completion pulse, port A.
REQ-007 SHALL have ports: rdata_a  out  16  read data, port A.
REQ-008 SHALL have ports: read_b / write_b  in  1 each  data-port requests, level, held until resp_b.
REQ-009 SHALL have ports: wmask_b  in  2  byte enables for write_b; address_b, wdata_b  in  16 each.
REQ-010 SHALL have ports: resp_b  out  1  completion pulse; rdata_b  out  16  read data, port B.
REQ-011 SHALL have ports: pmem_read, pmem_write  out  1 each; pmem_wmask  out  2; pmem_address, pmem_wdata  out  16 each.
REQ-012 SHALL have ports: pmem_resp  in  1  backing-memory completion; pmem_rdata  in  16  backing read data.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B.
REQ-014 SHALL, in IDLE, sample requests: request_b = read_b|write_b; request_a = read_a.
REQ-015 SHALL on both requests in IDLE grant the port not granted last time if its pending-fairness flag is set, else apply B_PRIORITY.
REQ-016 SHALL set the pending-fairness flag for the losing port on a contested grant; clear it when that port is granted.
REQ-017 SHALL latch address, wdata, wmask and op (write_b over read_b if both high) into request registers at grant; transition IDLE->SERVE_x.
REQ-018 SHALL drive pmem_* only from the latched request, only in SERVE_x; pmem_read/pmem_write SHALL be 0 in all other states.
REQ-019 SHALL, in SERVE_x, hold pmem outputs stable until pmem_resp=1, then capture pmem_rdata (reads only) into rdata_x and go to DONE_x.
REQ-020 SHALL assert resp_x=1 for exactly the DONE_x cycle, then return to IDLE; new requests are not sampled in DONE_x.
REQ-021 SHALL leave rdata_x unchanged on writes and hold it between transactions.
REQ-022 SHALL give minimum latency: request in IDLE cycle N -> pmem request N+1 -> pmem_resp at cycle M -> resp_x at M+1.
REQ-023 SHALL ignore pmem_resp in IDLE and DONE_x.
REQ-024 SHALL ignore request-input changes during SERVE_x (latched values govern).
REQ-025 SHALL never assert resp_a and resp_b in the same cycle.

Reset
REQ-026 SHALL on rst=1 asynchronously enter IDLE, clear fairness flags, request registers, rdata_a, rdata_b to 0, and drive all outputs 0.
REQ-027 SHALL abandon any in-flight pmem transaction on reset mid-SERVE; a late pmem_resp after reset release SHALL be ignored.

Structure
REQ-028 SHALL use lc3b_word and lc3b_mem_wmask from package lc3b_types; the arbiter state enum SHALL be local to mem_arbiter.
REQ-029 SHALL be a single flat module; no sub-module.

Verification
REQ-030 SHALL cover: read_a, address_a=0x0040, pmem_resp 3 cycles later with pmem_rdata=0x1234 -> resp_a one cycle, rdata_a=0x1234, pmem_address=0x0040.
REQ-031 SHALL cover: write_b, address_b=0x8000, wdata_b=0xBEEF, wmask_b=2'b01 -> pmem_write=1, pmem_wmask=01, resp_b pulse, rdata_b unchanged.
REQ-032 SHALL cover: read_a and read_b same IDLE cycle, B_PRIORITY=1 -> B served first, A served next even if B re-requests immediately.
REQ-033 SHALL cover: address_b changed 0x0010->0x0020 mid-SERVE_B -> pmem_address stays 0x0010.
REQ-034 SHALL cover: rst pulsed during SERVE_A, then pmem_resp=1 after release -> no resp_a, state IDLE, outputs 0.
REQ-035 SHALL cover: read_b and write_b both high -> pmem_write=1, pmem_read=0.
